// File: rtl/iir_ctrl_pkg.sv
// Shared types and constants for the IIR notch-chain coefficient controller.
// The optional readback check is enabled with COEFF_VERIFY_EN (see iir_coeff_ctrl).
package iir_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitGap,
        StCommit,
        StVerify,
        StSettle
    } ctrl_state_e;

    localparam logic [1:0] SEL_1MHZ   = 2'd0;
    localparam logic [1:0] SEL_2MHZ   = 2'd1;
    localparam logic [1:0] SEL_2_4MHZ = 2'd2;
    localparam logic [1:0] SEL_ALL    = 2'd3;

    localparam int unsigned NUM_COEFF   = 3;
    localparam int unsigned DEN_COEFF   = 2;
    localparam int unsigned COEFF_DEPTH = NUM_COEFF + DEN_COEFF;

    // Value 1.0 in a signed fixed-point word of the given width and fraction bits.
    function automatic logic [63:0] unity_coeff(input int unsigned width, input int unsigned frac);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (64'd1 << frac) & mask;
    endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// One per-stage shadow bank of five coefficient registers (b0,b1,b2,a1,a2).
// Resets to a unity pass-through filter: b0 = 1.0, all others 0.
module iir_coeff_bank
    import iir_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned FRAC  = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] coeff [COEFF_DEPTH]
);

    localparam logic [WIDTH-1:0] UnityB0 = WIDTH'(unity_coeff(WIDTH, FRAC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < COEFF_DEPTH; k++) begin
                coeff[k] <= (k == 0) ? UnityB0 : '0;
            end
        end else if (wr_en && (wr_idx < 3'(COEFF_DEPTH))) begin
            coeff[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Coefficient controller for the 1 MHz / 2 MHz / 2.4 MHz notch stages: shadow writes, gap-aligned
// commit pulses and settle timing. Define COEFF_VERIFY_EN to add the post-commit readback check.
module iir_coeff_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = 20,
    parameter int unsigned COEFF_FRAC  = 18,
    parameter int unsigned MAX_WAIT    = 64,
    parameter int unsigned SETTLE      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_commit,
    input  logic [1:0]             cfg_sel,
    input  logic [2:0]             cfg_idx,
    input  logic [COEFF_WIDTH-1:0] cfg_data,
    input  logic                   sample_valid,
    output logic [COEFF_WIDTH-1:0] coeff_in_1MHz   [COEFF_DEPTH],
    output logic [COEFF_WIDTH-1:0] coeff_in_2MHz   [COEFF_DEPTH],
    output logic [COEFF_WIDTH-1:0] coeff_in_2_4MHz [COEFF_DEPTH],
    output logic                   coeff_wr_en_1MHz,
    output logic                   coeff_wr_en_2MHz,
    output logic                   coeff_wr_en_2_4MHz,
    input  logic [COEFF_WIDTH-1:0] coeff_out_1MHz   [COEFF_DEPTH],
    input  logic [COEFF_WIDTH-1:0] coeff_out_2MHz   [COEFF_DEPTH],
    input  logic [COEFF_WIDTH-1:0] coeff_out_2_4MHz [COEFF_DEPTH],
    output logic                   busy,
    output logic                   done,
    output logic                   err_cfg,
    output logic                   err_timeout,
    output logic                   verify_err
);

    localparam int unsigned WaitW   = $clog2(MAX_WAIT + 1);
    localparam int unsigned SettleW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    ctrl_state_e        state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic               err_cfg_q, err_cfg_d;
    logic               err_timeout_q, err_timeout_d;
    logic [2:0]         stage_mask, stage_wr_en, bank_we;
    logic               wr_legal, wr_fire;

    assign wr_legal   = (cfg_sel != SEL_ALL) && (cfg_idx < 3'(COEFF_DEPTH));
    assign wr_fire    = cfg_valid && cfg_ready && !cfg_commit && wr_legal;
    assign bank_we    = wr_fire ? (3'b001 << cfg_sel) : 3'b000;
    assign stage_mask = (sel_q == SEL_ALL) ? 3'b111 : (3'b001 << sel_q);

    iir_coeff_bank #(.WIDTH(COEFF_WIDTH), .FRAC(COEFF_FRAC)) u_bank_1mhz (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_we[SEL_1MHZ]),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_data),
        .coeff   (coeff_in_1MHz)
    );

    iir_coeff_bank #(.WIDTH(COEFF_WIDTH), .FRAC(COEFF_FRAC)) u_bank_2mhz (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_we[SEL_2MHZ]),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_data),
        .coeff   (coeff_in_2MHz)
    );

    iir_coeff_bank #(.WIDTH(COEFF_WIDTH), .FRAC(COEFF_FRAC)) u_bank_2_4mhz (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_we[SEL_2_4MHZ]),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_data),
        .coeff   (coeff_in_2_4MHz)
    );

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        sel_d         = sel_q;
        err_cfg_d     = 1'b0;
        err_timeout_d = 1'b0;
        cfg_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        stage_wr_en   = 3'b000;

        unique case (state_q)
            StIdle: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) begin
                    if (cfg_commit) begin
                        sel_d      = cfg_sel;
                        wait_cnt_d = '0;
                        state_d    = StWaitGap;
                    end else begin
                        err_cfg_d = !wr_legal;
                    end
                end
            end
            StWaitGap: begin
                if (!sample_valid) begin
                    state_d = StCommit;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    // No gap within MAX_WAIT samples: force the load anyway and flag it.
                    if (wait_cnt_d == WaitW'(MAX_WAIT)) begin
                        state_d       = StCommit;
                        err_timeout_d = 1'b1;
                    end
                end
            end
            StCommit: begin
                stage_wr_en  = stage_mask;
                settle_cnt_d = SettleW'(SETTLE);
`ifdef COEFF_VERIFY_EN
                state_d      = StVerify;
`else
                state_d      = StSettle;
`endif
            end
            StVerify: begin
                state_d = StSettle;
            end
            StSettle: begin
                if (settle_cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            sel_q         <= SEL_1MHZ;
            err_cfg_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            sel_q         <= sel_d;
            err_cfg_q     <= err_cfg_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign coeff_wr_en_1MHz   = stage_wr_en[SEL_1MHZ];
    assign coeff_wr_en_2MHz   = stage_wr_en[SEL_2MHZ];
    assign coeff_wr_en_2_4MHz = stage_wr_en[SEL_2_4MHZ];
    assign err_cfg            = err_cfg_q;
    assign err_timeout        = err_timeout_q;

`ifdef COEFF_VERIFY_EN
    logic verify_err_q, verify_err_d, mismatch;

    // Shadows cannot change outside IDLE, so they still hold the committed set here.
    always_comb begin
        mismatch = 1'b0;
        for (int k = 0; k < COEFF_DEPTH; k++) begin
            mismatch |= stage_mask[SEL_1MHZ] && (coeff_out_1MHz[k] != coeff_in_1MHz[k]);
            mismatch |= stage_mask[SEL_2MHZ] && (coeff_out_2MHz[k] != coeff_in_2MHz[k]);
            mismatch |= stage_mask[SEL_2_4MHZ] && (coeff_out_2_4MHz[k] != coeff_in_2_4MHz[k]);
        end
    end

    always_comb begin
        verify_err_d = verify_err_q;
        if ((state_q == StIdle) && cfg_valid && cfg_commit) begin
            verify_err_d = 1'b0;
        end else if (state_q == StVerify) begin
            verify_err_d = verify_err_q | mismatch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_err_q <= 1'b0;
        end else begin
            verify_err_q <= verify_err_d;
        end
    end

    assign verify_err = verify_err_q;
`else
    logic unused_readback;

    always_comb begin
        unused_readback = 1'b0;
        for (int k = 0; k < COEFF_DEPTH; k++) begin
            unused_readback = unused_readback ^ (^coeff_out_1MHz[k]) ^ (^coeff_out_2MHz[k])
                              ^ (^coeff_out_2_4MHz[k]);
        end
    end

    assign verify_err = 1'b0;
`endif

endmodule
